// File: rtl/nios_ii_system_gpio_irq.sv
// Bidirectional GPIO Avalon-MM slave: per-bit direction, atomic set/clear,
// synchronised inputs, edge capture and a maskable level interrupt.
module nios_ii_system_gpio_irq #(
   parameter int unsigned WIDTH       = 7,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = 0,
   parameter logic [31:0] RESET_OUT   = 32'h0,
   parameter logic [31:0] RESET_DIR   = 32'h0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   inout  wire  [WIDTH-1:0]  bidir_port,
   output logic              irq
);

   localparam logic [WIDTH-1:0] RST_OUT = WIDTH'(RESET_OUT);
   localparam logic [WIDTH-1:0] RST_DIR = WIDTH'(RESET_DIR);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_DIR    = 3'd1;
   localparam logic [2:0] A_MASK   = 3'd2;
   localparam logic [2:0] A_EDGE   = 3'd3;
   localparam logic [2:0] A_OUTSET = 3'd4;
   localparam logic [2:0] A_OUTCLR = 3'd5;

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] data_dir_q, data_dir_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic             wr_c;
   logic [WIDTH-1:0] wd_c;
   logic [WIDTH-1:0] sync_c;
   logic [WIDTH-1:0] ev_c;
   logic [WIDTH-1:0] clr_c;
   logic             unused_wd;

   assign wr_c      = chipselect & ~write_n;
   assign wd_c      = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;
   assign sync_c    = sync_q[SYNC_STAGES-1];

   // Pins are driven straight from the direction/output registers.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin
      assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
   end

   always_comb begin
      sync_d[0] = bidir_port;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_d[k] = sync_q[k-1];
      prev_d = sync_c;
   end

   always_comb begin
      ev_c = sync_c & ~prev_q;
      if (EDGE_TYPE == 1)      ev_c = ~sync_c & prev_q;
      else if (EDGE_TYPE == 2) ev_c = sync_c ^ prev_q;
   end

   // Register writes; a capture event in the same cycle as its W1C wins.
   always_comb begin
      data_out_d = data_out_q;
      data_dir_d = data_dir_q;
      irq_mask_d = irq_mask_q;
      clr_c      = '0;
      if (wr_c) begin
         case (address)
            A_DATA:   data_out_d = wd_c;
            A_DIR:    data_dir_d = wd_c;
            A_MASK:   irq_mask_d = wd_c;
            A_EDGE:   clr_c      = wd_c;
            A_OUTSET: data_out_d = data_out_q | wd_c;
            A_OUTCLR: data_out_d = data_out_q & ~wd_c;
            default:  ;
         endcase
      end
      edge_cap_d = (edge_cap_q & ~clr_c) | ev_c;
      irq_d      = |(edge_cap_q & irq_mask_q);
   end

   always_comb begin
      readdata_d = 32'h0;
      case (address)
         A_DATA:   readdata_d = 32'(sync_c);
         A_DIR:    readdata_d = 32'(data_dir_q);
         A_MASK:   readdata_d = 32'(irq_mask_q);
         A_EDGE:   readdata_d = 32'(edge_cap_q);
         A_OUTSET: readdata_d = 32'(data_out_q);
         A_OUTCLR: readdata_d = 32'(data_out_q);
         default:  readdata_d = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= RST_OUT;
         data_dir_q <= RST_DIR;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         prev_q     <= '0;
         readdata_q <= 32'h0;
         irq_q      <= 1'b0;
         for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      end else begin
         data_out_q <= data_out_d;
         data_dir_q <= data_dir_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         prev_q     <= prev_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
         for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_d[k];
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_nios_ii_system_gpio_irq.sv
// Self-checking bench for nios_ii_system_gpio_irq (WIDTH=7, SYNC_STAGES=2, rising edges).
module tb_nios_ii_system_gpio_irq;

   localparam int unsigned W = 7;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   wire  [W-1:0] bidir_port;
   logic        irq;

   logic [W-1:0] tb_oe;
   logic [W-1:0] tb_val;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   typedef struct {
      int          op;     // 0 idle, 1 write, 2 read, 3 pin check
      logic [2:0]  addr;
      logic [31:0] data;   // write data or expected value
      string       name;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   for (genvar i = 0; i < int'(W); i++) begin : g_drv
      assign bidir_port[i] = tb_oe[i] ? tb_val[i] : 1'bz;
   end

   nios_ii_system_gpio_irq #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .bidir_port (bidir_port),
      .irq        (irq)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      if (a == 3'd1) tb_oe = ~d[W-1:0];
   endtask

   // Expected readback is queued when the address is driven, checked when it appears.
   task automatic bus_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
      logic [31:0] ev;
      string       en;
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      tick();
      chipselect = 1'b0;
      ev = exp_q.pop_front();
      en = name_q.pop_front();
      check(en, readdata, ev);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      tb_oe      = '1;
      tb_val     = '0;

      // Reset state, register map and T2 output/set/clear sequence
      tbl.push_back('{2, 3'd1, 32'h00, "rst_dir"});
      tbl.push_back('{2, 3'd0, 32'h00, "rst_data"});
      tbl.push_back('{2, 3'd3, 32'h00, "rst_edge"});
      tbl.push_back('{2, 3'd2, 32'h00, "rst_mask"});
      tbl.push_back('{1, 3'd2, 32'hFFFF_FFFF, ""});
      tbl.push_back('{2, 3'd2, 32'h7F, "mask_upper_ignored"});
      tbl.push_back('{1, 3'd2, 32'h00, ""});
      tbl.push_back('{1, 3'd6, 32'hFF, ""});
      tbl.push_back('{2, 3'd6, 32'h00, "addr6_zero"});
      tbl.push_back('{1, 3'd7, 32'hFF, ""});
      tbl.push_back('{2, 3'd7, 32'h00, "addr7_zero"});
      tbl.push_back('{2, 3'd1, 32'h00, "dir_after_67"});
      tbl.push_back('{1, 3'd1, 32'h7F, ""});
      tbl.push_back('{1, 3'd0, 32'h55, ""});
      tbl.push_back('{1, 3'd4, 32'h02, ""});
      tbl.push_back('{1, 3'd5, 32'h01, ""});
      tbl.push_back('{2, 3'd4, 32'h56, "outset_read"});
      tbl.push_back('{2, 3'd5, 32'h56, "outclr_read"});
      tbl.push_back('{2, 3'd1, 32'h7F, "dir_read"});
      tbl.push_back('{3, 3'd0, 32'h56, "pins_t2"});
      tbl.push_back('{0, 3'd0, 32'h00, ""});
      tbl.push_back('{0, 3'd0, 32'h00, ""});
      tbl.push_back('{0, 3'd0, 32'h00, ""});
      tbl.push_back('{2, 3'd0, 32'h56, "data_out_driven"});
      tbl.push_back('{2, 3'd3, 32'h57, "edge_on_outputs"});
      tbl.push_back('{1, 3'd3, 32'h7F, ""});
      tbl.push_back('{2, 3'd3, 32'h00, "edge_w1c_all"});
      tbl.push_back('{1, 3'd1, 32'h00, ""});
      tbl.push_back('{0, 3'd0, 32'h00, ""});
      tbl.push_back('{0, 3'd0, 32'h00, ""});
      tbl.push_back('{0, 3'd0, 32'h00, ""});
      tbl.push_back('{0, 3'd0, 32'h00, ""});
      tbl.push_back('{2, 3'd3, 32'h00, "falls_not_captured"});
      tbl.push_back('{2, 3'd0, 32'h00, "data_inputs_low"});

      idle(3);
      check("rst_irq", 32'(irq), 32'h0);
      reset_n = 1'b1;
      tick();

      foreach (tbl[i]) begin
         case (tbl[i].op)
            1:       bus_wr(tbl[i].addr, tbl[i].data);
            2:       bus_rd(tbl[i].addr, tbl[i].data, tbl[i].name);
            3:       check(tbl[i].name, 32'(bidir_port), tbl[i].data);
            default: tick();
         endcase
      end

      // T3: DATA latency on pin3 rise
      tb_val = 7'h08;
      bus_rd(3'd0, 32'h00, "t3_data_e1");
      bus_rd(3'd0, 32'h00, "t3_data_e2");
      bus_rd(3'd0, 32'h08, "t3_data_e3");
      // capture latency on pin5 rise (bit3 already captured)
      tb_val = 7'h28;
      bus_rd(3'd3, 32'h08, "t3_edge_e1");
      bus_rd(3'd3, 32'h08, "t3_edge_e2");
      bus_rd(3'd3, 32'h08, "t3_edge_e3");
      bus_rd(3'd3, 32'h28, "t3_edge_e4");
      bus_wr(3'd3, 32'h20);
      tb_val = 7'h00;
      idle(4);
      bus_rd(3'd3, 32'h08, "t3_fall_no_set");
      check("t3_irq_unmasked", 32'(irq), 32'h0);

      // T4: mask then W1C
      bus_wr(3'd2, 32'h08);
      check("t4_irq_mask_edge", 32'(irq), 32'h0);
      tick();
      check("t4_irq_assert", 32'(irq), 32'h1);
      bus_wr(3'd3, 32'h08);
      check("t4_irq_clr_edge", 32'(irq), 32'h1);
      tick();
      check("t4_irq_deassert", 32'(irq), 32'h0);
      bus_rd(3'd3, 32'h00, "t4_edge_cleared");

      // T5: W1C coinciding with a new rising edge
      tb_val = 7'h08;
      idle(5);
      check("t5_irq_pre", 32'(irq), 32'h1);
      tb_val = 7'h00;
      idle(4);
      tb_val = 7'h08;
      idle(2);
      bus_wr(3'd3, 32'h08);
      check("t5_irq_hold0", 32'(irq), 32'h1);
      bus_rd(3'd3, 32'h08, "t5_set_wins");
      check("t5_irq_hold1", 32'(irq), 32'h1);
      bus_wr(3'd3, 32'h08);
      bus_rd(3'd3, 32'h00, "t5_plain_w1c");

      // T6: asynchronous reset with irq high and all pins driven
      bus_wr(3'd1, 32'h7F);
      bus_wr(3'd2, 32'h7F);
      idle(4);
      check("t6_irq_pre", 32'(irq), 32'h1);
      address = 3'd1;
      idle(1);
      check("t6_dir_pre", readdata, 32'h7F);
      #3;
      reset_n = 1'b0;
      #1;
      check("t6_irq_async", 32'(irq), 32'h0);
      check("t6_rd_async", readdata, 32'h0);
      tb_oe      = '1;
      tb_val     = '0;
      address    = 3'd1;
      writedata  = 32'h7F;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      reset_n    = 1'b1;
      bus_rd(3'd1, 32'h00, "t6_dir");
      bus_rd(3'd2, 32'h00, "t6_mask");
      bus_rd(3'd3, 32'h00, "t6_edge");
      bus_rd(3'd4, 32'h00, "t6_out");
      bus_rd(3'd0, 32'h00, "t6_data");
      check("t6_irq_after", 32'(irq), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
